// File: rtl/la_acq_pkg.sv
// Shared types for the logic-analyzer acquisition sequencer.
package la_acq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ARM  = 2'd2,
    POST = 2'd3
  } la_acq_st_t;

endpackage

// File: rtl/la_acq_ctl.sv
// Acquisition sequencer: gates the sample stream into a single acquisition
// (pre-trigger fill, armed wait for trigger, post-trigger count, TLAST) and
// reports sequencer status back to the register bank.
// The incoming stream TLAST carries no meaning here, so it has no port.
module la_acq_ctl
  import la_acq_pkg::*;
#(
  parameter int unsigned DN = 2,
  parameter type         DT = logic [8-1:0],
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ctl_rst,
  input  logic          ctl_acq,
  input  logic          ctl_stp,
  input  logic          ctl_trg,
  input  logic [CW-1:0] cfg_pre,
  input  logic [CW-1:0] cfg_pst,
  input  logic [DN-1:0] trg_in,
  output logic          sts_acq,
  output logic          sts_trg,
  output logic          sts_stp,
  output logic [CW-1:0] sts_pre,
  output logic [CW-1:0] sts_pst,
  output logic          irq,
  input  logic          sti_tvalid,
  output logic          sti_tready,
  input  DT [DN-1:0]    sti_tdata,
  input  logic [DN-1:0] sti_tkeep,
  output logic          sto_tvalid,
  input  logic          sto_tready,
  output DT [DN-1:0]    sto_tdata,
  output logic [DN-1:0] sto_tkeep,
  output logic          sto_tlast
);

  la_acq_st_t    st, st_nxt;
  logic [CW-1:0] cfg_pre_q, cfg_pst_q;
  logic [CW-1:0] cnt_pre, cnt_pst;
  logic          swp;
  logic          active, xfer, btrg;
  logic          start, pre_inc, pst_inc, trg_hit, done, stop;

  // Zero-latency stream gating: pass-through while active, drain while idle.
  always_comb begin
    active     = (st != IDLE);
    sto_tvalid = active & sti_tvalid;
    sti_tready = active ? sto_tready : 1'b1;
    sto_tdata  = sti_tdata;
    sto_tkeep  = sti_tkeep;
    xfer       = sti_tvalid & sti_tready;
    btrg       = (|trg_in) | swp;
    sto_tlast  = done;
  end

  // Next-state and per-cycle strobes; soft reset and abort override stream events.
  always_comb begin
    st_nxt  = st;
    start   = 1'b0;
    pre_inc = 1'b0;
    pst_inc = 1'b0;
    trg_hit = 1'b0;
    done    = 1'b0;
    stop    = 1'b0;
    if (ctl_rst) begin
      st_nxt = IDLE;
    end else if (ctl_stp && active) begin
      stop   = 1'b1;
      st_nxt = IDLE;
    end else begin
      unique case (st)
        IDLE: begin
          if (ctl_acq && !ctl_stp) begin
            start  = 1'b1;
            st_nxt = PRE;
          end
        end
        PRE: begin
          pre_inc = xfer;
          if (cfg_pre_q == '0 || (xfer && (cnt_pre + CW'(1)) == cfg_pre_q))
            st_nxt = ARM;
        end
        ARM: begin
          pre_inc = xfer;
          if (xfer && btrg) begin
            trg_hit = 1'b1;
            if (cfg_pst_q == '0) begin
              done   = 1'b1;
              st_nxt = IDLE;
            end else begin
              st_nxt = POST;
            end
          end
        end
        POST: begin
          pst_inc = xfer;
          if (xfer && (cnt_pst + CW'(1)) == cfg_pst_q) begin
            done   = 1'b1;
            st_nxt = IDLE;
          end
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= IDLE;
    else       st <= st_nxt;
  end

  // Configuration snapshot, beat counters, sticky status and the pending software trigger.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_pre_q <= '0;
      cfg_pst_q <= '0;
      cnt_pre   <= '0;
      cnt_pst   <= '0;
      sts_trg   <= 1'b0;
      sts_stp   <= 1'b0;
      swp       <= 1'b0;
      irq       <= 1'b0;
    end else if (ctl_rst) begin
      cfg_pre_q <= '0;
      cfg_pst_q <= '0;
      cnt_pre   <= '0;
      cnt_pst   <= '0;
      sts_trg   <= 1'b0;
      sts_stp   <= 1'b0;
      swp       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      irq <= done;
      if (start) begin
        cfg_pre_q <= cfg_pre;
        cfg_pst_q <= cfg_pst;
        cnt_pre   <= '0;
        cnt_pst   <= '0;
        sts_trg   <= 1'b0;
        sts_stp   <= 1'b0;
      end
      if (pre_inc && cnt_pre != '1) cnt_pre <= cnt_pre + CW'(1);
      if (pst_inc)                  cnt_pst <= cnt_pst + CW'(1);
      if (trg_hit)                  sts_trg <= 1'b1;
      if (stop)                     sts_stp <= 1'b1;
      // A software trigger is held only while armed and is consumed by the next armed beat.
      if (st_nxt != ARM)             swp <= 1'b0;
      else if (st == ARM && ctl_trg) swp <= 1'b1;
      else if (st == ARM && xfer)    swp <= 1'b0;
    end
  end

  assign sts_acq = (st != IDLE);
  assign sts_pre = cnt_pre;
  assign sts_pst = cnt_pst;

endmodule

// File: tb/tb_la_acq_ctl.sv
// Self-checking bench for la_acq_ctl: randomized stream handshakes against a
// count-based acquisition model; each scenario task checks its own results.
module tb_la_acq_ctl;

  localparam int DN = 2;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rstn, ctl_rst, ctl_acq, ctl_stp, ctl_trg;
  logic [CW-1:0]        cfg_pre, cfg_pst;
  logic [DN-1:0]        trg_in;
  logic                 sts_acq, sts_trg, sts_stp, irq;
  logic [CW-1:0]        sts_pre, sts_pst;
  logic                 sti_tvalid, sti_tready, sto_tvalid, sto_tready, sto_tlast;
  logic [DN-1:0][7:0]   sti_tdata, sto_tdata;
  logic [DN-1:0]        sti_tkeep, sto_tkeep;

  la_acq_ctl #(.DN(DN), .DT(logic [7:0]), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .ctl_rst(ctl_rst), .ctl_acq(ctl_acq), .ctl_stp(ctl_stp),
    .ctl_trg(ctl_trg), .cfg_pre(cfg_pre), .cfg_pst(cfg_pst), .trg_in(trg_in),
    .sts_acq(sts_acq), .sts_trg(sts_trg), .sts_stp(sts_stp), .sts_pre(sts_pre),
    .sts_pst(sts_pst), .irq(irq),
    .sti_tvalid(sti_tvalid), .sti_tready(sti_tready), .sti_tdata(sti_tdata), .sti_tkeep(sti_tkeep),
    .sto_tvalid(sto_tvalid), .sto_tready(sto_tready), .sto_tdata(sto_tdata), .sto_tkeep(sto_tkeep),
    .sto_tlast(sto_tlast)
  );

  int errors = 0;
  int checks = 0;

  // Stimulus knobs
  int pv = 100, pr = 100;
  bit hold_valid = 1'b0;
  bit trg_set [0:63];

  // Reference model: one acquisition described by flags and beat counts
  bit          m_act, m_armed, m_trg, m_stp, m_pend, m_irq_next;
  int unsigned m_pre, m_pst, m_cpre, m_cpst, m_nbeat;

  // Logs
  logic [18:0] obs_q[$], exp_q[$];
  int obs_irq, exp_irq, hs_bad, reg_bad;

  task automatic model_clear();
    m_act = 0; m_armed = 0; m_trg = 0; m_stp = 0; m_pend = 0; m_irq_next = 0;
    m_pre = 0; m_pst = 0; m_cpre = 0; m_cpst = 0; m_nbeat = 0;
  endtask

  task automatic clear_logs();
    obs_q.delete(); exp_q.delete();
    obs_irq = 0; exp_irq = 0; hs_bad = 0; reg_bad = 0;
    pv = 100; pr = 100; hold_valid = 0;
    foreach (trg_set[i]) trg_set[i] = 0;
  endtask

  task automatic model_step();
    bit rdy, x, in_arm, new_arm, btrg, fin;
    rdy = m_act ? sto_tready : 1'b1;
    x = sti_tvalid && rdy;
    in_arm = m_act && m_armed && !m_trg;
    btrg = (trg_in != '0) || m_pend;
    fin = 0;
    m_irq_next = 0;
    if (ctl_rst) begin
      if (m_act && x) exp_q.push_back({sti_tkeep, sti_tdata, 1'b0});
      model_clear();
    end else if (ctl_stp && m_act) begin
      if (x) exp_q.push_back({sti_tkeep, sti_tdata, 1'b0});
      m_act = 0;
      m_stp = 1;
    end else if (!m_act) begin
      if (ctl_acq && !ctl_stp) begin
        m_act = 1; m_armed = 0; m_trg = 0; m_stp = 0;
        m_pre = 0; m_pst = 0; m_nbeat = 0;
        m_cpre = cfg_pre; m_cpst = cfg_pst;
      end
    end else begin
      if (x) m_nbeat++;
      if (!m_armed) begin
        if (x) m_pre++;
        if (m_cpre == 0 || (x && m_pre == m_cpre)) m_armed = 1;
      end else if (!m_trg) begin
        if (x) begin
          m_pre++;
          if (btrg) begin
            m_trg = 1;
            if (m_cpst == 0) fin = 1;
          end
        end
      end else if (x) begin
        m_pst++;
        if (m_pst == m_cpst) fin = 1;
      end
      if (x) exp_q.push_back({sti_tkeep, sti_tdata, fin});
      if (fin) begin
        m_act = 0;
        m_irq_next = 1;
      end
    end
    new_arm = m_act && m_armed && !m_trg;
    if (!new_arm)                 m_pend = 0;
    else if (in_arm && ctl_trg)   m_pend = 1;
    else if (in_arm && x)         m_pend = 0;
  endtask

  // One clock: drive at posedge+1, observe stream at negedge, observe registers at posedge+1.
  task automatic tick();
    sti_tvalid = hold_valid ? 1'b0 : ($urandom_range(99) < pv);
    sto_tready = ($urandom_range(99) < pr);
    sti_tdata  = 16'($urandom);
    sti_tkeep  = 2'($urandom);
    trg_in     = (m_nbeat + 1 < 64 && trg_set[m_nbeat + 1]) ? 2'($urandom_range(3, 1)) : '0;
    @(negedge clk);
    if (sti_tready !== (m_act ? sto_tready : 1'b1) || sto_tvalid !== (m_act & sti_tvalid)) hs_bad++;
    if (sto_tvalid && sto_tready) obs_q.push_back({sto_tkeep, sto_tdata, sto_tlast});
    else if (sto_tlast) hs_bad++;
    model_step();
    @(posedge clk);
    #1;
    if (irq) obs_irq++;
    if (m_irq_next) exp_irq++;
    if (irq !== m_irq_next || sts_acq !== m_act || sts_trg !== m_trg || sts_stp !== m_stp ||
        sts_pre !== CW'(m_pre) || sts_pst !== CW'(m_pst)) reg_bad++;
  endtask

  task automatic start(input int unsigned pre, input int unsigned pst);
    cfg_pre = pre;
    cfg_pst = pst;
    ctl_acq = 1;
    tick();
    ctl_acq = 0;
    cfg_pre = $urandom;
    cfg_pst = $urandom;
  endtask

  task automatic run_idle(input int budget);
    for (int i = 0; i < budget && m_act; i++) tick();
    if (m_act) begin
      checks++; errors++;
      $display("FAIL run_idle_timeout: still active after %0d cycles, want idle", budget);
    end
  endtask

  function automatic int beats_bad();
    int n;
    n = 0;
    if (obs_q.size() != exp_q.size()) n++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  function automatic int last_count();
    int n;
    n = 0;
    foreach (obs_q[i]) if (obs_q[i][0]) n++;
    return n;
  endfunction

  task automatic test_reset();
    rstn = 0; ctl_rst = 0; ctl_acq = 0; ctl_stp = 0; ctl_trg = 0;
    cfg_pre = '0; cfg_pst = '0; trg_in = '0;
    sti_tvalid = 0; sto_tready = 0; sti_tdata = '0; sti_tkeep = '0;
    model_clear();
    clear_logs();
    #12;
    checks++; if (sts_acq !== 1'b0) begin errors++; $display("FAIL reset_sts_acq: got %b want 0", sts_acq); end
    checks++; if (sts_pre !== '0 || sts_pst !== '0) begin errors++; $display("FAIL reset_counts: got pre=%0d pst=%0d want 0 0", sts_pre, sts_pst); end
    checks++; if (sts_trg !== 1'b0 || sts_stp !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL reset_flags: got trg=%b stp=%b irq=%b want 0 0 0", sts_trg, sts_stp, irq); end
    checks++; if (sti_tready !== 1'b1 || sto_tvalid !== 1'b0) begin errors++; $display("FAIL reset_stream: got rdy=%b vld=%b want 1 0", sti_tready, sto_tvalid); end
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clear_logs();
    pv = 70;
    trg_set[6] = 1;
    start(4, 3);
    run_idle(300);
    checks++; if (obs_q.size() != 9) begin errors++; $display("FAIL basic_beats: got %0d want 9", obs_q.size()); end
    checks++; if (beats_bad() != 0) begin errors++; $display("FAIL basic_data: got %0d bad beats want 0", beats_bad()); end
    checks++; if (last_count() != 1 || (obs_q.size() > 0 && obs_q[obs_q.size()-1][0] !== 1'b1)) begin errors++; $display("FAIL basic_tlast: got %0d lasts want 1 on final beat", last_count()); end
    checks++; if (obs_irq != 1) begin errors++; $display("FAIL basic_irq: got %0d pulses want 1", obs_irq); end
    checks++; if (sts_trg !== 1'b1 || sts_pre !== 32'd6 || sts_pst !== 32'd3) begin errors++; $display("FAIL basic_sts: got trg=%b pre=%0d pst=%0d want 1 6 3", sts_trg, sts_pre, sts_pst); end
    checks++; if (hs_bad != 0 || reg_bad != 0) begin errors++; $display("FAIL basic_cycle: got hs=%0d reg=%0d bad cycles want 0 0", hs_bad, reg_bad); end
  endtask

  task automatic test_pre_ignore();
    clear_logs();
    pv = 60; pr = 80;
    trg_set[2] = 1; trg_set[4] = 1; trg_set[7] = 1;
    start(4, 2);
    run_idle(400);
    checks++; if (sts_pre !== 32'd7) begin errors++; $display("FAIL pre_ignore_sts_pre: got %0d want 7", sts_pre); end
    checks++; if (obs_q.size() != 9 || beats_bad() != 0) begin errors++; $display("FAIL pre_ignore_beats: got %0d beats %0d bad want 9 0", obs_q.size(), beats_bad()); end
    checks++; if (obs_irq != 1 || sts_trg !== 1'b1) begin errors++; $display("FAIL pre_ignore_done: got irq=%0d trg=%b want 1 1", obs_irq, sts_trg); end
  endtask

  task automatic test_zero_len();
    clear_logs();
    trg_set[1] = 1;
    hold_valid = 1;
    start(0, 0);
    tick();
    hold_valid = 0;
    run_idle(50);
    checks++; if (obs_q.size() != 1 || last_count() != 1) begin errors++; $display("FAIL zero_beats: got %0d beats %0d lasts want 1 1", obs_q.size(), last_count()); end
    checks++; if (obs_irq != 1 || sts_acq !== 1'b0) begin errors++; $display("FAIL zero_done: got irq=%0d acq=%b want 1 0", obs_irq, sts_acq); end
    checks++; if (sts_pre !== 32'd1 || sts_pst !== 32'd0 || reg_bad != 0) begin errors++; $display("FAIL zero_sts: got pre=%0d pst=%0d reg=%0d want 1 0 0", sts_pre, sts_pst, reg_bad); end
  endtask

  task automatic test_sw_trigger();
    clear_logs();
    start(2, 3);
    for (int i = 0; i < 20 && !m_armed; i++) tick();
    repeat (3) tick();
    ctl_trg = 1; pr = 0;
    tick();
    ctl_trg = 0;
    repeat (4) tick();
    pr = 100;
    run_idle(50);
    checks++; if (sts_trg !== 1'b1 || sts_pre !== 32'd6) begin errors++; $display("FAIL swtrg_sts: got trg=%b pre=%0d want 1 6", sts_trg, sts_pre); end
    checks++; if (obs_q.size() != 9 || beats_bad() != 0) begin errors++; $display("FAIL swtrg_beats: got %0d beats %0d bad want 9 0", obs_q.size(), beats_bad()); end
    checks++; if (obs_irq != 1 || hs_bad != 0 || reg_bad != 0) begin errors++; $display("FAIL swtrg_cycle: got irq=%0d hs=%0d reg=%0d want 1 0 0", obs_irq, hs_bad, reg_bad); end
  endtask

  task automatic test_stop();
    clear_logs();
    trg_set[4] = 1;
    start(3, 5);
    for (int i = 0; i < 50 && m_pst < 2; i++) tick();
    ctl_stp = 1;
    tick();
    ctl_stp = 0; pr = 0;
    tick();
    checks++; if (sts_stp !== 1'b1 || sts_acq !== 1'b0) begin errors++; $display("FAIL stop_sts: got stp=%b acq=%b want 1 0", sts_stp, sts_acq); end
    checks++; if (last_count() != 0 || obs_irq != 0) begin errors++; $display("FAIL stop_no_end: got lasts=%0d irq=%0d want 0 0", last_count(), obs_irq); end
    checks++; if (sti_tready !== 1'b1 || sts_pst !== 32'd2) begin errors++; $display("FAIL stop_idle: got rdy=%b pst=%0d want 1 2", sti_tready, sts_pst); end
    checks++; if (beats_bad() != 0 || reg_bad != 0) begin errors++; $display("FAIL stop_cycle: got bad=%0d reg=%0d want 0 0", beats_bad(), reg_bad); end
  endtask

  task automatic test_async_reset();
    clear_logs();
    trg_set[3] = 1;
    start(2, 6);
    for (int i = 0; i < 50 && !(m_trg && m_pst >= 1); i++) tick();
    rstn = 0;
    #2;
    checks++; if (sts_acq !== 1'b0 || sts_trg !== 1'b0 || sts_stp !== 1'b0) begin errors++; $display("FAIL arst_flags: got acq=%b trg=%b stp=%b want 0 0 0", sts_acq, sts_trg, sts_stp); end
    checks++; if (sts_pre !== '0 || sts_pst !== '0 || irq !== 1'b0) begin errors++; $display("FAIL arst_counts: got pre=%0d pst=%0d irq=%b want 0 0 0", sts_pre, sts_pst, irq); end
    model_clear();
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;
    clear_logs();
    pv = 50; pr = 70;
    trg_set[5] = 1;
    start(3, 2);
    run_idle(400);
    checks++; if (sts_pre !== 32'd5 || sts_pst !== 32'd2 || obs_irq != 1) begin errors++; $display("FAIL arst_rerun: got pre=%0d pst=%0d irq=%0d want 5 2 1", sts_pre, sts_pst, obs_irq); end
    checks++; if (beats_bad() != 0 || reg_bad != 0 || hs_bad != 0) begin errors++; $display("FAIL arst_rerun_cycle: got bad=%0d reg=%0d hs=%0d want 0 0 0", beats_bad(), reg_bad, hs_bad); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      clear_logs();
      pv = $urandom_range(100, 30);
      pr = $urandom_range(100, 30);
      foreach (trg_set[i]) trg_set[i] = ($urandom_range(99) < 15);
      for (int c = 0; c < 300; c++) begin
        cfg_pre = $urandom_range(5);
        cfg_pst = $urandom_range(5);
        ctl_acq = m_act ? ($urandom_range(19) == 0) : ($urandom_range(7) == 0);
        ctl_trg = ($urandom_range(7) == 0);
        ctl_stp = ($urandom_range(59) == 0);
        ctl_rst = ($urandom_range(79) == 0);
        tick();
      end
      ctl_acq = 0; ctl_trg = 0; ctl_stp = 0; ctl_rst = 0;
      checks++; if (beats_bad() != 0) begin errors++; $display("FAIL random_%0d_beats: got %0d bad (obs %0d exp %0d) want 0", it, beats_bad(), obs_q.size(), exp_q.size()); end
      checks++; if (hs_bad != 0 || reg_bad != 0) begin errors++; $display("FAIL random_%0d_cycle: got hs=%0d reg=%0d want 0 0", it, hs_bad, reg_bad); end
      checks++; if (obs_irq != exp_irq) begin errors++; $display("FAIL random_%0d_irq: got %0d want %0d", it, obs_irq, exp_irq); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pre_ignore();
    test_zero_len();
    test_sw_trigger();
    test_stop();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
